// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
// Ports: clk/reset (sync, active-high); DivStartE, DivOpE, SrcAE, SrcBE, FlushE in;
// DivResultE (quotient/remainder), DivValidE (one-cycle pulse), DivStall (pipeline hold) out.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            DivStartE,
  input  logic [1:0]      DivOpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            FlushE,
  output logic [XLEN-1:0] DivResultE,
  output logic            DivValidE,
  output logic            DivStall
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, div_q, div_d, res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic sa_q, sa_d, sb_q, sb_d;
  logic start, sgn_in, div_zero, ovf, special, ge;
  logic [XLEN:0] shifted, diff;
  logic [XLEN-1:0] q_fix, r_fix;
  always_comb begin
    start    = (state_q == IDLE) & DivStartE & ~FlushE;
    sgn_in   = ~DivOpE[0];
    div_zero = SrcBE == '0;
    ovf      = sgn_in & (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) & (&SrcBE);
    special  = div_zero | ovf;
    shifted  = {rem_q, quo_q[XLEN-1]};
    diff     = shifted - {1'b0, div_q};
    ge       = ~diff[XLEN];
    q_fix    = (~op_q[0] & (sa_q ^ sb_q)) ? -quo_q : quo_q;
    r_fix    = (~op_q[0] & sa_q) ? -rem_q : rem_q;
  end
  always_comb begin
    state_d = FlushE            ? IDLE :
              state_q == IDLE   ? (DivStartE ? (special ? DONE : CALC) : IDLE) :
              state_q == CALC   ? (cnt_q == '0 ? FIXUP : CALC) :
              state_q == FIXUP  ? DONE : IDLE;
    quo_d = quo_q;
    rem_d = rem_q;
    div_d = div_q;
    res_d = res_q;
    cnt_d = cnt_q;
    op_d  = op_q;
    sa_d  = sa_q;
    sb_d  = sb_q;
    if (start) begin
      op_d  = DivOpE;
      sa_d  = SrcAE[XLEN-1];
      sb_d  = SrcBE[XLEN-1];
      quo_d = (sgn_in & SrcAE[XLEN-1]) ? -SrcAE : SrcAE;
      div_d = (sgn_in & SrcBE[XLEN-1]) ? -SrcBE : SrcBE;
      rem_d = '0;
      cnt_d = CW'(XLEN-1);
      // Overflow case quotient equals the dividend (-2^(XLEN-1)), remainder 0.
      res_d = special ? (div_zero ? (DivOpE[1] ? SrcAE : '1) : (DivOpE[1] ? '0 : SrcAE)) : res_q;
    end else if (state_q == CALC) begin
      rem_d = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], ge};
      cnt_d = cnt_q - 1'b1;
    end else if (state_q == FIXUP && !FlushE) begin
      res_d = op_q[1] ? r_fix : q_fix;
    end
  end
  always_comb begin
    DivValidE  = state_q == DONE;
    DivStall   = ~FlushE & ((state_q == IDLE & DivStartE) | state_q == CALC | state_q == FIXUP);
    DivResultE = res_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  end
endmodule
